// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous input in system-clock cycles.
// Latency: a result is registered 2 clocks after sig_in is first sampled high (2-flop sync + edge detect).
// Backpressure: valid/ready; an unaccepted result is overwritten and the sticky overrun flag is set.
module clock_period_meter #(
    parameter int unsigned      WIDTH   = 24,
    parameter logic [WIDTH-1:0] TIMEOUT = 24'hFFFFFF
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic             overrun,
    output logic             stalled
);

    typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_t;

    state_t           state;
    logic             s1;
    logic             s2;
    logic             s3;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hcnt;
    logic             rise;

    assign rise = s2 & ~s3;

    always_ff @(posedge clock) begin
        if (!rst) begin
            state      <= IDLE;
            s1         <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            cnt        <= '0;
            hcnt       <= '0;
            meas_valid <= 1'b0;
            period     <= '0;
            high_time  <= '0;
            overrun    <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;

            // Both counters saturate at TIMEOUT so long gaps never wrap into a bogus short period.
            if (rise) begin
                cnt  <= WIDTH'(1);
                hcnt <= WIDTH'(1);
            end else begin
                if (cnt != TIMEOUT) begin
                    cnt <= cnt + 1'b1;
                end
                if (s2 && (hcnt != TIMEOUT)) begin
                    hcnt <= hcnt + 1'b1;
                end
            end

            if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= MEASURE;
                        stalled <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period     <= cnt;
                        high_time  <= hcnt;
                        meas_valid <= 1'b1;
                        // A result accepted in this same cycle is not lost, so only flag when unaccepted.
                        if (meas_valid && !meas_ready) begin
                            overrun <= 1'b1;
                        end
                    end else if (cnt == TIMEOUT) begin
                        state   <= IDLE;
                        stalled <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter: event-level reference model plus directed and random waveforms.
module tb_clock_period_meter;

    localparam int TMO = 20;

    logic        clock;
    logic        rst;
    logic        sig_in;
    logic        meas_ready;
    logic        meas_valid;
    logic [23:0] period;
    logic [23:0] high_time;
    logic        overrun;
    logic        stalled;

    int checks;
    int errors;

    clock_period_meter #(.WIDTH(24), .TIMEOUT(24'd20)) dut (
        .clock      (clock),
        .rst        (rst),
        .sig_in     (sig_in),
        .meas_ready (meas_ready),
        .meas_valid (meas_valid),
        .period     (period),
        .high_time  (high_time),
        .overrun    (overrun),
        .stalled    (stalled)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: input transitions take effect two edges after they are sampled;
    // results are timestamp differences between effective transitions.
    typedef struct {
        int t;
        bit rise;
    } ev_t;

    ev_t evq[$];
    int  now;
    bit  prev_v;
    bit  armed;
    int  last_rise;
    int  last_fall;
    bit  fall_after;
    bit  e_valid;
    bit  e_over;
    bit  e_stall;
    int  e_period;
    int  e_high;
    int  coinc;
    bit  res;
    bit  rise_now;
    bit  fall_now;
    int  p;
    int  h;

    initial begin
        now = 0; prev_v = 0; armed = 0; last_rise = 0; last_fall = 0; fall_after = 0;
        e_valid = 0; e_over = 0; e_stall = 0; e_period = 0; e_high = 0; coinc = 0;
    end

    always @(posedge clock) begin
        now = now + 1;
        if (!rst) begin
            evq.delete();
            prev_v = 0; armed = 0; fall_after = 0;
            e_valid = 0; e_over = 0; e_stall = 0; e_period = 0; e_high = 0;
        end else begin
            rise_now = 0; fall_now = 0; res = 0; p = 0; h = 0;
            while (evq.size() > 0 && evq[0].t == now) begin
                if (evq[0].rise) rise_now = 1; else fall_now = 1;
                evq.delete(0);
            end
            if (sig_in != prev_v) evq.push_back('{now + 2, sig_in});
            prev_v = sig_in;

            if (fall_now) begin
                last_fall  = now;
                fall_after = 1;
            end
            if (rise_now) begin
                if (armed) begin
                    res = 1;
                    p   = now - last_rise;
                    h   = fall_after ? last_fall - last_rise : p;
                end else begin
                    armed   = 1;
                    e_stall = 0;
                end
                last_rise  = now;
                fall_after = 0;
            end else if (armed && (now - last_rise == TMO)) begin
                armed   = 0;
                e_stall = 1;
            end

            if (res) begin
                if (e_valid && meas_ready) coinc = coinc + 1;
                if (e_valid && !meas_ready) e_over = 1;
                e_valid  = 1;
                e_period = p;
                e_high   = h;
            end else if (e_valid && meas_ready) begin
                e_valid = 0;
            end
        end
    end

    function automatic bit result_next();
        return armed && evq.size() > 0 && evq[0].t == now + 1 && evq[0].rise;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        chk("meas_valid", {31'b0, meas_valid}, {31'b0, e_valid});
        chk("period",     {8'b0, period},      e_period);
        chk("high_time",  {8'b0, high_time},   e_high);
        chk("overrun",    {31'b0, overrun},    {31'b0, e_over});
        chk("stalled",    {31'b0, stalled},    {31'b0, e_stall});
    endtask

    // rmode: 0 ready low, 1 ready high, 2 random, 3 ready only when a result lands on a held one
    task automatic set_ready(input int rmode);
        case (rmode)
            0:       meas_ready = 1'b0;
            1:       meas_ready = 1'b1;
            2:       meas_ready = 1'($urandom_range(0, 1));
            default: meas_ready = e_valid && result_next();
        endcase
    endtask

    task automatic wave(input int hi, input int lo, input int rmode);
        sig_in = 1'b1;
        repeat (hi) begin
            set_ready(rmode);
            tick();
        end
        sig_in = 1'b0;
        repeat (lo) begin
            set_ready(rmode);
            tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0; sig_in = 1'b0; meas_ready = 1'b0;
        tick();
        tick();
        chk("reset_valid",  {31'b0, meas_valid}, 0);
        chk("reset_period", {8'b0, period},      0);
        chk("reset_stall",  {31'b0, stalled},    0);
        rst = 1'b1;
        tick();

        // 5/5 square wave with ready held
        repeat (4) wave(5, 5, 1);
        chk("sq55_period", {8'b0, period},    10);
        chk("sq55_high",   {8'b0, high_time}, 5);

        // 3 high / 7 low
        repeat (3) wave(3, 7, 1);
        chk("duty37_high", {8'b0, high_time}, 3);
        chk("duty37_ovr",  {31'b0, overrun},  0);

        // results pile up unaccepted
        repeat (3) wave(4, 4, 0);
        chk("bp_valid",  {31'b0, meas_valid}, 1);
        chk("bp_period", {8'b0, period},      8);
        chk("bp_ovr",    {31'b0, overrun},    1);
        meas_ready = 1'b1;
        tick();
        chk("bp_drain_valid", {31'b0, meas_valid}, 0);
        chk("bp_drain_ovr",   {31'b0, overrun},    1);

        // stall after a long low, then re-arm without a result
        wave(3, 25, 1);
        chk("stall_set", {31'b0, stalled}, 1);
        wave(3, 5, 1);
        chk("stall_clr", {31'b0, stalled}, 0);
        wave(3, 5, 1);
        chk("rearm_period", {8'b0, period}, 8);

        // rise coincides with counter reaching TIMEOUT
        wave(5, 15, 1);
        wave(5, 15, 1);
        chk("tmo_period", {8'b0, period},   TMO);
        chk("tmo_stall",  {31'b0, stalled}, 0);

        // reset mid-period while a result is held
        repeat (2) wave(4, 4, 0);
        sig_in = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_valid", {31'b0, meas_valid}, 0);
        chk("mid_rst_ovr",   {31'b0, overrun},    0);
        chk("mid_rst_per",   {8'b0, period},      0);
        chk("mid_rst_high",  {8'b0, high_time},   0);
        rst = 1'b1;
        tick();
        tick();
        sig_in = 1'b0;
        repeat (4) tick();
        wave(4, 4, 1);
        wave(4, 4, 1);

        // acceptance in the same cycle as a new result
        repeat (5) wave(4, 4, 3);
        chk("coinc_seen", {31'b0, (coinc > 0)}, 1);
        chk("coinc_ovr",  {31'b0, overrun},     0);

        // random waveforms and backpressure, with occasional stalls
        for (int i = 0; i < 150; i++) begin
            int hi_n;
            int lo_n;
            hi_n = $urandom_range(2, 12);
            lo_n = ($urandom_range(0, 9) == 0) ? 24 : $urandom_range(2, 12);
            wave(hi_n, lo_n, 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
